// File: rtl/f32_pkg.sv
// Shared binary32 definitions for the iterative divider and its rounding stage.
// Holds the format constants, the packed-result constructors and the divider
// state encoding.
package f32_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } state_t;

    function automatic logic [31:0] f32_inf(input logic s);
        return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    endfunction

    function automatic logic [31:0] f32_zero(input logic s);
        return {s, {(EXP_W + FRAC_W){1'b0}}};
    endfunction

endpackage

// File: rtl/f32_round_pack.sv
// Round-to-nearest-even and pack for a binary32 result.
// Ports:
//   s   : result sign
//   e   : signed 10-bit biased exponent matching m's hidden bit
//   m   : 24-bit significand, m[23] is the hidden 1
//   g   : guard bit below m[0]
//   st  : sticky OR of everything below the guard
//   res : packed result; overflow gives inf, e<=0 flushes to signed zero
module f32_round_pack
    import f32_pkg::*;
(
    input  logic              s,
    input  logic signed [9:0] e,
    input  logic [23:0]       m,
    input  logic              g,
    input  logic              st,
    output logic [31:0]       res
);

    logic              rnd;
    logic [23:0]       frac_sum;
    logic              carry;
    logic signed [9:0] e_fin;

    always_comb begin
        rnd      = g & (st | m[0]);
        // Incrementing only the fraction: a carry out of it together with the
        // hidden bit is the significand overflow, and the fraction wraps to 0,
        // which is exactly the 0x800000 significand.
        frac_sum = {1'b0, m[22:0]} + {23'b0, rnd};
        carry    = frac_sum[23] & m[23];
        e_fin    = carry ? e + 10'sd1 : e;
        if (int'(e_fin) >= EXP_MAX) begin
            res = f32_inf(s);
        end else if (int'(e_fin) <= 0) begin
            res = f32_zero(s);
        end else begin
            res = {s, e_fin[7:0], frac_sum[22:0]};
        end
    end

endmodule

// File: rtl/f32div_iter.sv
// Iterative binary32 divider, out = x / y, one restoring radix-2 step per cycle.
// Subnormal inputs flush to zero, RNE rounding, underflow flushes to zero,
// NaN results are the canonical quiet NaN.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   x, y                : dividend, divisor
//   out_valid/out_ready : result handshake (out_valid registered)
//   out                 : registered quotient, stable while stalled
module f32div_iter
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    state_t            state, state_n;
    logic [4:0]        cnt;
    logic [24:0]       r;
    logic [25:0]       q;
    logic [23:0]       my;
    logic signed [9:0] e;
    logic              s;

    logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic              special;
    logic [31:0]       special_val;
    logic signed [9:0] e_init;

    logic              rnd_g, rnd_st;
    logic [23:0]       rnd_m;
    logic signed [9:0] rnd_e;
    logic [31:0]       packed_res;

    assign in_ready = (state == IDLE);

    always_comb begin
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);

        special     = 1'b1;
        special_val = QNAN;
        if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
            special_val = QNAN;
        end else if (x_inf || y_zero) begin
            special_val = f32_inf(x[31] ^ y[31]);
        end else if (x_zero || y_inf) begin
            special_val = f32_zero(x[31] ^ y[31]);
        end else begin
            special = 1'b0;
        end

        e_init = $signed({2'b00, x[30:23]}) - $signed({2'b00, y[30:23]})
                 + $signed(10'(BIAS));
    end

    // A leading quotient bit of 0 means the quotient is in [0.5,1): take the
    // significand one position lower and drop the exponent by one.
    always_comb begin
        if (q[25]) begin
            rnd_m  = q[25:2];
            rnd_g  = q[1];
            rnd_st = q[0] | (r != '0);
            rnd_e  = e;
        end else begin
            rnd_m  = q[24:1];
            rnd_g  = q[0];
            rnd_st = (r != '0);
            rnd_e  = e - 10'sd1;
        end
    end

    f32_round_pack u_round_pack (
        .s   (s),
        .e   (rnd_e),
        .m   (rnd_m),
        .g   (rnd_g),
        .st  (rnd_st),
        .res (packed_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = special ? DONE : DIV;
            DIV:     if (cnt == 5'd25) state_n = ROUND;
            ROUND:   state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            r         <= '0;
            q         <= '0;
            my        <= '0;
            e         <= '0;
            s         <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s <= x[31] ^ y[31];
                        if (special) begin
                            out       <= special_val;
                            out_valid <= 1'b1;
                        end else begin
                            my  <= {1'b1, y[22:0]};
                            r   <= {2'b01, x[22:0]};
                            q   <= '0;
                            cnt <= '0;
                            e   <= e_init;
                        end
                    end
                end
                DIV: begin
                    if (r >= {1'b0, my}) begin
                        r <= (r - {1'b0, my}) << 1;
                        q <= {q[24:0], 1'b1};
                    end else begin
                        r <= r << 1;
                        q <= {q[24:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    out       <= packed_res;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
